// File: rtl/watch_ctrl_if.sv
// Button inputs and time-counter controls of the watch front end.
interface watch_ctrl_if;
  logic       btn_mode;
  logic       btn_sel;
  logic       btn_up;
  logic       btn_down;
  logic       clock_en;
  logic [5:0] digit;
  logic       up;
  logic       down;
  logic       set_mode;

  modport master (
    output btn_mode, btn_sel, btn_up, btn_down,
    input  clock_en, digit, up, down, set_mode
  );

  modport slave (
    input  btn_mode, btn_sel, btn_up, btn_down,
    output clock_en, digit, up, down, set_mode
  );
endinterface

// File: rtl/watch_ctrl.sv
// Watch front end: button sync/debounce, RUN/SET mode FSM, digit cursor,
// up/down adjust pulses with auto-repeat, and the 1 Hz count enable.
module watch_ctrl #(
  parameter int DB_CYCLES     = 60000,
  parameter int TICK_DIV      = 6000000,
  parameter int REPEAT_DELAY  = 3000000,
  parameter int REPEAT_PERIOD = 1200000
) (
  input  logic         clk_6mhz,
  input  logic         rst_n,
  watch_ctrl_if.slave  bus
);

  localparam int NB   = 4;
  localparam int BM   = 0;  // mode
  localparam int BS   = 1;  // digit select
  localparam int BU   = 2;  // up
  localparam int BD   = 3;  // down
  localparam int DBW  = $clog2(DB_CYCLES + 1);
  localparam int TW   = $clog2(TICK_DIV + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0]  DLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]  PER_LAST  = RW'(REPEAT_PERIOD - 1);

  typedef enum logic {S_RUN, S_SET} state_t;

  logic [NB-1:0]          w_raw;
  logic [NB-1:0]          r_sync1, r_sync2;
  logic [NB-1:0]          r_stable;
  logic [NB-1:0]          r_press;
  logic [NB-1:0][DBW-1:0] r_db_cnt;

  state_t          r_state;
  logic            r_clock_en, r_up, r_down, r_set_mode;
  logic [5:0]      r_digit;
  logic [TW-1:0]   r_pre;
  logic            r_rep_act;    // a held up/down is being tracked for repeat
  logic            r_rep_dir;    // 0 = up, 1 = down
  logic            r_rep_phase;  // 0 = waiting initial delay, 1 = periodic
  logic [RW-1:0]   r_rep_cnt;

  logic            w_both, w_held;
  logic [RW-1:0]   w_rep_lim;

  assign w_raw     = {bus.btn_down, bus.btn_up, bus.btn_sel, bus.btn_mode};
  assign w_both    = r_stable[BU] & r_stable[BD];
  assign w_held    = r_rep_dir ? r_stable[BD] : r_stable[BU];
  assign w_rep_lim = r_rep_phase ? PER_LAST : DLY_LAST;

  // Two-flop synchroniser for the asynchronous raw buttons
  always_ff @(posedge clk_6mhz) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncers: accept a new level after DB_CYCLES consecutive mismatched
  // samples; a rising accepted level yields a one-cycle press event
  always_ff @(posedge clk_6mhz) begin
    if (!rst_n) begin
      r_db_cnt <= '0;
      r_stable <= '0;
      r_press  <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] != r_stable[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_stable[i] <= r_sync2[i];
            r_db_cnt[i] <= '0;
            r_press[i]  <= r_sync2[i];
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Mode FSM with cursor, adjust/repeat pulses and prescaler; mode press
  // wins over everything else, and the prescaler is parked at 0 in SET
  always_ff @(posedge clk_6mhz) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_set_mode  <= 1'b0;
      r_digit     <= '0;
      r_clock_en  <= 1'b0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_pre       <= '0;
      r_rep_act   <= 1'b0;
      r_rep_dir   <= 1'b0;
      r_rep_phase <= 1'b0;
      r_rep_cnt   <= '0;
    end else begin
      r_up       <= 1'b0;
      r_down     <= 1'b0;
      r_clock_en <= 1'b0;
      if (r_press[BM]) begin
        r_rep_act <= 1'b0;
        r_pre     <= '0;
        if (r_state == S_RUN) begin
          r_state    <= S_SET;
          r_set_mode <= 1'b1;
          r_digit    <= 6'b000001;
        end else begin
          r_state    <= S_RUN;
          r_set_mode <= 1'b0;
          r_digit    <= '0;
        end
      end else if (r_state == S_RUN) begin
        if (r_pre == TICK_LAST) begin
          r_pre      <= '0;
          r_clock_en <= 1'b1;
        end else begin
          r_pre <= r_pre + TW'(1);
        end
      end else begin
        r_pre <= '0;
        if (r_press[BS])
          r_digit <= {r_digit[4:0], r_digit[5]};
        if (w_both) begin
          r_rep_act <= 1'b0;
        end else if (r_press[BU]) begin
          r_up        <= 1'b1;
          r_rep_act   <= 1'b1;
          r_rep_dir   <= 1'b0;
          r_rep_phase <= 1'b0;
          r_rep_cnt   <= '0;
        end else if (r_press[BD]) begin
          r_down      <= 1'b1;
          r_rep_act   <= 1'b1;
          r_rep_dir   <= 1'b1;
          r_rep_phase <= 1'b0;
          r_rep_cnt   <= '0;
        end else if (r_rep_act) begin
          if (!w_held) begin
            r_rep_act <= 1'b0;
          end else if (r_rep_cnt == w_rep_lim) begin
            r_up        <= ~r_rep_dir;
            r_down      <= r_rep_dir;
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b1;
          end else begin
            r_rep_cnt <= r_rep_cnt + RW'(1);
          end
        end
      end
    end
  end

  assign bus.clock_en = r_clock_en;
  assign bus.digit    = r_digit;
  assign bus.up       = r_up;
  assign bus.down     = r_down;
  assign bus.set_mode = r_set_mode;

endmodule
